// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline control logic.
// Contents:
//   op_e          - instruction opcode encoding (ir[3:0])
//   ex_state_e    - execute-stage sequencing states
//   ALU_*         - ALU operation select codes
//   OP_MSB/OP_LSB - opcode field position, IMM_BIT - immediate/jump-form flag
//   f_jump_taken  - jump condition evaluation shared by execute and decode
package cpu_pkg;

  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;
  localparam int IMM_BIT = 4;

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_MVHI = 4'd6,
    OP_J    = 4'd8,
    OP_JZ   = 4'd9,
    OP_JN   = 4'd10,
    OP_CALL = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MEM    = 2'd1,
    ST_SQUASH = 2'd2
  } ex_state_e;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  // Condition check only; validity/squash qualification is the caller's job.
  function automatic logic f_jump_taken(input logic [3:0] op, input logic n, input logic z);
    logic taken;
    case (op)
      OP_J, OP_CALL: taken = 1'b1;
      OP_JZ:         taken = z;
      OP_JN:         taken = n;
      default:       taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_execute_control_if.sv
// Data-memory handshake between the execute stage and data memory.
// Signals:
//   mem_rd          - read request (execute -> memory)
//   mem_wr          - write request (execute -> memory)
//   mem_waitrequest - memory not ready (memory -> execute)
// Modports: master = execute control, slave = data memory.
interface cpu_execute_control_if;

  logic mem_rd;
  logic mem_wr;
  logic mem_waitrequest;

  modport master (
    output mem_rd,
    output mem_wr,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    output mem_waitrequest
  );

endinterface

// File: rtl/cpu_jump_detect.sv
// Combinational jump resolution for one instruction word.
// Ports:
//   i_ir     - instruction word ([3:0] opcode, [4] immediate form)
//   i_n/i_z  - negative / zero flags
//   o_jump_i - jump taken, immediate form
//   o_jump_r - jump taken, register form
// Outputs are not qualified by instruction validity; the user gates them.
module cpu_jump_detect
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  input  logic        i_n,
  input  logic        i_z,
  output logic        o_jump_i,
  output logic        o_jump_r
);

  logic w_taken;
  logic w_unused_hi;

  // Only opcode and form bits matter for jump resolution.
  assign w_unused_hi = ^i_ir[15:IMM_BIT+1];

  assign w_taken  = f_jump_taken(i_ir[OP_MSB:OP_LSB], i_n, i_z);
  // Form bit selects exactly one of the two outputs, never both.
  assign o_jump_i = w_taken &  i_ir[IMM_BIT];
  assign o_jump_r = w_taken & ~i_ir[IMM_BIT];

endmodule

// File: rtl/cpu_execute_control.sv
// Execute-stage control for the 16-bit pipelined CPU.
// Decodes ir_ex, resolves jumps against N/Z, sequences load/store
// handshakes with a pipeline stall, squashes wrong-path instructions after
// a taken jump and registers the writeback valid qualifier.
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   i_ir_ex, i_ex_valid    - instruction in execute and its valid bit
//   i_n, i_z               - current flags
//   mem_bus (master)       - data memory rd/wr request and waitrequest
//   o_ex_jump_i/_r, o_pc_sel - taken jump (to decode control / PC mux)
//   o_alu_op, o_alu_b_sel  - ALU operation and B-operand select
//   o_nz_ld                - flag load
//   o_stall                - freeze front of pipeline
//   o_lr_wr                - write return address (call)
//   o_ir_wr_ld             - load ir_wr
//   o_wr_valid             - registered writeback valid
// All combinational outputs are forced low while reset_n is low.
module cpu_execute_control
  import cpu_pkg::*;
#(
  parameter int SQUASH_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [15:0]                  i_ir_ex,
  input  logic                         i_ex_valid,
  input  logic                         i_n,
  input  logic                         i_z,
  cpu_execute_control_if.master        mem_bus,
  output logic                         o_ex_jump_i,
  output logic                         o_ex_jump_r,
  output logic                         o_pc_sel,
  output logic [1:0]                   o_alu_op,
  output logic                         o_alu_b_sel,
  output logic                         o_nz_ld,
  output logic                         o_stall,
  output logic                         o_lr_wr,
  output logic                         o_ir_wr_ld,
  output logic                         o_wr_valid
);

  localparam logic [1:0] SQ_LOAD = SQUASH_CYCLES[1:0];

  ex_state_e   r_state;
  logic [1:0]  r_sq_cnt;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_wr_valid;

  logic [3:0]  w_opcode;
  logic        w_imm;
  logic        w_effective;
  logic        w_raw_jump_i;
  logic        w_raw_jump_r;

  logic [1:0]  w_dec_alu_op;
  logic        w_dec_nz_ld;
  logic        w_dec_ld;
  logic        w_dec_st;
  logic        w_dec_call;

  logic        w_jump_i;
  logic        w_jump_r;
  logic [1:0]  w_alu_op;
  logic        w_alu_b_sel;
  logic        w_nz_ld;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic        w_stall;
  logic        w_lr_wr;
  logic        w_ir_wr_ld;

  assign w_opcode = i_ir_ex[OP_MSB:OP_LSB];
  assign w_imm    = i_ir_ex[IMM_BIT];

  // Reset is folded in so every side effect is suppressed while held.
  assign w_effective = reset_n & i_ex_valid & (r_state != ST_SQUASH);

  cpu_jump_detect u_jump_detect (
    .i_ir     (i_ir_ex),
    .i_n      (i_n),
    .i_z      (i_z),
    .o_jump_i (w_raw_jump_i),
    .o_jump_r (w_raw_jump_r)
  );

  // Opcode decode, independent of validity and state.
  always_comb begin
    w_dec_alu_op = ALU_PASS;
    w_dec_nz_ld  = 1'b0;
    w_dec_ld     = 1'b0;
    w_dec_st     = 1'b0;
    w_dec_call   = 1'b0;
    case (w_opcode)
      OP_ADD: begin
        w_dec_alu_op = ALU_ADD;
        w_dec_nz_ld  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        w_dec_alu_op = ALU_SUB;
        w_dec_nz_ld  = 1'b1;
      end
      OP_LD:   w_dec_ld   = 1'b1;
      OP_ST:   w_dec_st   = 1'b1;
      OP_CALL: w_dec_call = 1'b1;
      default: w_dec_alu_op = ALU_PASS;
    endcase
  end

  // Output qualification by reset, effectiveness and sequencing state.
  always_comb begin
    w_jump_i    = 1'b0;
    w_jump_r    = 1'b0;
    w_alu_op    = ALU_PASS;
    w_alu_b_sel = 1'b0;
    w_nz_ld     = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_stall     = 1'b0;
    w_lr_wr     = 1'b0;
    w_ir_wr_ld  = 1'b0;
    if (!reset_n) begin
      w_ir_wr_ld = 1'b0;
    end else begin
      w_alu_op    = w_dec_alu_op;
      w_alu_b_sel = w_imm;
      w_nz_ld     = w_effective & w_dec_nz_ld;
      case (r_state)
        ST_RUN: begin
          w_jump_i = w_effective & w_raw_jump_i;
          w_jump_r = w_effective & w_raw_jump_r;
          w_lr_wr  = w_effective & w_dec_call;
          w_mem_rd = w_effective & w_dec_ld;
          w_mem_wr = w_effective & w_dec_st;
          // Waitrequest only matters when a request is actually issued.
          w_stall  = (w_mem_rd | w_mem_wr) & mem_bus.mem_waitrequest;
        end
        ST_MEM: begin
          // Request replayed from the registered copy so it stays stable.
          w_mem_rd = r_mem_rd;
          w_mem_wr = r_mem_wr;
          w_stall  = mem_bus.mem_waitrequest;
        end
        ST_SQUASH: begin
          w_stall = 1'b0;
        end
        default: begin
          w_stall = 1'b0;
        end
      endcase
      w_ir_wr_ld = ~w_stall;
    end
  end

  // Sequencing FSM, squash counter, held memory request and writeback valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_sq_cnt   <= 2'd0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_wr_valid <= 1'b0;
    end else begin
      if (w_ir_wr_ld) begin
        r_wr_valid <= w_effective;
      end else begin
        r_wr_valid <= r_wr_valid;
      end
      case (r_state)
        ST_RUN: begin
          if (w_jump_i | w_jump_r) begin
            r_state  <= ST_SQUASH;
            r_sq_cnt <= SQ_LOAD;
          end else if (w_stall) begin
            r_state  <= ST_MEM;
            r_mem_rd <= w_mem_rd;
            r_mem_wr <= w_mem_wr;
          end else begin
            r_state  <= ST_RUN;
          end
        end
        ST_MEM: begin
          if (!mem_bus.mem_waitrequest) begin
            r_state  <= ST_RUN;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
          end else begin
            r_state  <= ST_MEM;
          end
        end
        ST_SQUASH: begin
          // Counter value N at entry squashes exactly N instructions.
          if (r_sq_cnt <= 2'd1) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= 2'd0;
          end else begin
            r_sq_cnt <= r_sq_cnt - 2'd1;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_sq_cnt <= 2'd0;
        end
      endcase
    end
  end

  assign o_ex_jump_i    = w_jump_i;
  assign o_ex_jump_r    = w_jump_r;
  assign o_pc_sel       = w_jump_i | w_jump_r;
  assign o_alu_op       = w_alu_op;
  assign o_alu_b_sel    = w_alu_b_sel;
  assign o_nz_ld        = w_nz_ld;
  assign o_stall        = w_stall;
  assign o_lr_wr        = w_lr_wr;
  assign o_ir_wr_ld     = w_ir_wr_ld;
  assign o_wr_valid     = r_wr_valid;
  assign mem_bus.mem_rd = w_mem_rd;
  assign mem_bus.mem_wr = w_mem_wr;

endmodule
